// File: rtl/uart_arb_pkg.sv
// Shared types for the UART register-write arbiter: FSM states, requester ids,
// register select encodings and a small requester helper.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_RX  = 1'b1
  } req_id_t;

  localparam logic REG_CTRL = 1'b0;
  localparam logic REG_DATA = 1'b1;

  // The requester that is not the given one.
  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_CPU) ? REQ_RX : REQ_CPU;
  endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the caller keeps the
// last_grant register. On a tie the requester that did not win last time wins.
module uart_rr_arb2
  import uart_arb_pkg::*;
(
  input  logic    cpu_req_i,
  input  logic    rx_req_i,
  input  req_id_t last_grant_i,
  output logic    valid_o,
  output req_id_t winner_o
);

  // Pick a winner among the active requests.
  always_comb begin
    valid_o  = cpu_req_i | rx_req_i;
    winner_o = REQ_CPU;
    if (cpu_req_i && rx_req_i) begin
      winner_o = other_id(last_grant_i);
    end else if (rx_req_i) begin
      winner_o = REQ_RX;
    end else begin
      winner_o = REQ_CPU;
    end
  end

endmodule

// File: rtl/uart_reg_wr_arbiter.sv
// UART register-write arbiter: serialises CPU and RX writes onto one registered
// write strobe with 4-phase req/ack handshakes and round-robin tie breaking.
// Optional feature: define UART_ARB_CONFLICT_CNT_EN to add a saturating count
// of IDLE cycles in which both requesters were asking (conflict_cnt_o).
module uart_reg_wr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef UART_ARB_CONFLICT_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_req_i,
  input  logic              cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic              cpu_ack_o,
  input  logic              rx_req_i,
  input  logic              rx_sel_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              rx_ack_o,
  output logic              wr_en_o,
  output logic              wr_sel_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o
`ifdef UART_ARB_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0]  conflict_cnt_o
`endif
);

  arb_state_t        state_q, state_d;
  req_id_t           last_grant_q, last_grant_d;
  req_id_t           win_q, win_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              rx_ack_q, rx_ack_d;
  logic              busy_q, busy_d;

  logic              arb_valid_s;
  req_id_t           arb_winner_s;
  logic              winner_req_s;

  uart_rr_arb2 u_rr_arb2 (
    .cpu_req_i    (cpu_req_i),
    .rx_req_i     (rx_req_i),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid_s),
    .winner_o     (arb_winner_s)
  );

  // Next state, grant capture and registered-output next values.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    sel_d        = sel_q;
    data_d       = data_q;
    winner_req_s = (win_q == REQ_CPU) ? cpu_req_i : rx_req_i;

    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          state_d      = WRITE;
          win_d        = arb_winner_s;
          last_grant_d = arb_winner_s;
          if (arb_winner_s == REQ_CPU) begin
            sel_d  = cpu_sel_i;
            data_d = cpu_data_i;
          end else begin
            sel_d  = rx_sel_i;
            data_d = rx_data_i;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!winner_req_s) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so the strobe and ack
    // appear in the cycle right after the grant edge.
    wr_en_d   = (state_d == WRITE);
    cpu_ack_d = wr_en_d && (win_d == REQ_CPU);
    rx_ack_d  = wr_en_d && (win_d == REQ_RX);
    busy_d    = (state_d != IDLE);
  end

  // State, grant and output registers; reset discards any in-flight write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_RX;
      win_q        <= REQ_CPU;
      sel_q        <= REG_CTRL;
      data_q       <= {DATA_W{1'b0}};
      wr_en_q      <= 1'b0;
      cpu_ack_q    <= 1'b0;
      rx_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      wr_en_q      <= wr_en_d;
      cpu_ack_q    <= cpu_ack_d;
      rx_ack_q     <= rx_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign cpu_ack_o = cpu_ack_q;
  assign rx_ack_o  = rx_ack_q;
  assign wr_sel_o  = sel_q;
  assign wr_data_o = data_q;
  assign busy_o    = busy_q;

`ifdef UART_ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of IDLE cycles with both requests asserted.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE) && cpu_req_i && rx_req_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Conflict counter register, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt_o = cnt_q;
`endif

endmodule
